// File: rtl/vga_pkg.sv
// Shared types for the mouse-to-pixel position path.
`timescale 1ns/1ps
package vga_pkg;

   typedef logic [11:0] pos_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ_HI,
      ACK_WAIT_LO
   } hs_state_e;

endpackage

// File: rtl/bit_sync.sv
// Generic single-bit synchroniser, async active-low reset; usable on either side of a crossing.
`timescale 1ns/1ps
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p <= '0;
      end else begin
         sync_p <= {sync_p[STAGES-2:0], d};
      end
   end

   assign q = sync_p[STAGES-1];

endmodule

// File: rtl/pos_handshake_tx.sv
// Source half of the mouse-position CDC: holds the newest xpos/ypos on a stable bus under a
// 4-phase req/ack handshake, coalescing updates that arrive while a transfer is in flight.
`timescale 1ns/1ps
module pos_handshake_tx
   import vga_pkg::*;
#(
   parameter int POS_W       = $bits(pos_t),
   parameter int SYNC_STAGES = 2,
   parameter int SKIP_DUP    = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk100MHz,
   input  logic             rst_n,
   input  logic             pos_valid,
   input  logic [POS_W-1:0] xpos_in,
   input  logic [POS_W-1:0] ypos_in,
   input  logic             ack_in,
   output logic             req_out,
   output logic [POS_W-1:0] xpos_bus,
   output logic [POS_W-1:0] ypos_bus,
   output logic             busy,
   output logic [CNT_W-1:0] drop_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   hs_state_e        state;
   logic             ack_sync;
   logic [POS_W-1:0] pend_x;
   logic [POS_W-1:0] pend_y;
   logic             pend_vld;
   logic             is_dup;
   logic             take_new;

   bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk100MHz),
      .rst_n (rst_n),
      .d     (ack_in),
      .q     (ack_sync)
   );

   // The bus registers only change on a launch, so they double as the last-sent pair.
   assign is_dup   = (SKIP_DUP != 0) && (xpos_in == xpos_bus) && (ypos_in == ypos_bus);
   assign take_new = pos_valid && !is_dup;

   always_ff @(posedge clk100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         req_out  <= 1'b0;
         busy     <= 1'b0;
         xpos_bus <= '0;
         ypos_bus <= '0;
         pend_x   <= '0;
         pend_y   <= '0;
         pend_vld <= 1'b0;
         drop_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A stuck-high ack blocks launches; updates meanwhile wait in pending.
               if (!ack_sync && take_new) begin
                  xpos_bus <= xpos_in;
                  ypos_bus <= ypos_in;
                  req_out  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= REQ_HI;
                  pend_vld <= 1'b0;
                  if (pend_vld) drop_cnt <= sat_inc(drop_cnt);
               end else if (!ack_sync && pend_vld) begin
                  xpos_bus <= pend_x;
                  ypos_bus <= pend_y;
                  req_out  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= REQ_HI;
                  pend_vld <= 1'b0;
               end else if (take_new) begin
                  pend_x   <= xpos_in;
                  pend_y   <= ypos_in;
                  pend_vld <= 1'b1;
                  if (pend_vld) drop_cnt <= sat_inc(drop_cnt);
               end
            end
            REQ_HI: begin
               if (ack_sync) begin
                  req_out <= 1'b0;
                  state   <= ACK_WAIT_LO;
               end
               if (take_new) begin
                  pend_x   <= xpos_in;
                  pend_y   <= ypos_in;
                  pend_vld <= 1'b1;
                  if (pend_vld) drop_cnt <= sat_inc(drop_cnt);
               end
            end
            ACK_WAIT_LO: begin
               if (!ack_sync) begin
                  // Transfer complete: the freshest sample wins over anything pending.
                  if (take_new) begin
                     xpos_bus <= xpos_in;
                     ypos_bus <= ypos_in;
                     req_out  <= 1'b1;
                     state    <= REQ_HI;
                     pend_vld <= 1'b0;
                     if (pend_vld) drop_cnt <= sat_inc(drop_cnt);
                  end else if (pend_vld) begin
                     xpos_bus <= pend_x;
                     ypos_bus <= pend_y;
                     req_out  <= 1'b1;
                     state    <= REQ_HI;
                     pend_vld <= 1'b0;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else if (take_new) begin
                  pend_x   <= xpos_in;
                  pend_y   <= ypos_in;
                  pend_vld <= 1'b1;
                  if (pend_vld) drop_cnt <= sat_inc(drop_cnt);
               end
            end
            default: begin
               req_out <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pos_handshake_tx.sv
// Bench for pos_handshake_tx: directed vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_pos_handshake_tx;

   localparam int W = 12;

   logic clk100MHz = 1'b0;
   logic clk74     = 1'b0;
   logic rst_n     = 1'b0;
   always #5 clk100MHz = ~clk100MHz;
   always #7 clk74     = ~clk74;

   logic [W-1:0] xin = '0;
   logic [W-1:0] yin = '0;
   logic pv = 1'b0, pv_nd = 1'b0, pv_sat = 1'b0;
   logic ack_man = 1'b0, man_mode = 1'b0, ack_sat = 1'b0;
   logic ack_m, ack_nd;
   logic ack_main;
   assign ack_main = man_mode ? ack_man : ack_m;

   logic         req_out, busy;
   logic [W-1:0] xpos_bus, ypos_bus;
   logic [15:0]  drop_cnt;
   logic         req_nd, busy_nd;
   logic [W-1:0] xbus_nd, ybus_nd;
   logic [15:0]  drop_nd;
   logic         req_sat, busy_sat;
   logic [W-1:0] xbus_sat, ybus_sat;
   logic [3:0]   drop_sat;

   pos_handshake_tx u_dut (
      .clk100MHz(clk100MHz), .rst_n(rst_n), .pos_valid(pv), .xpos_in(xin), .ypos_in(yin),
      .ack_in(ack_main), .req_out(req_out), .xpos_bus(xpos_bus), .ypos_bus(ypos_bus),
      .busy(busy), .drop_cnt(drop_cnt));

   pos_handshake_tx #(.SKIP_DUP(0)) u_nd (
      .clk100MHz(clk100MHz), .rst_n(rst_n), .pos_valid(pv_nd), .xpos_in(xin), .ypos_in(yin),
      .ack_in(ack_nd), .req_out(req_nd), .xpos_bus(xbus_nd), .ypos_bus(ybus_nd),
      .busy(busy_nd), .drop_cnt(drop_nd));

   pos_handshake_tx #(.CNT_W(4)) u_sat (
      .clk100MHz(clk100MHz), .rst_n(rst_n), .pos_valid(pv_sat), .xpos_in(xin), .ypos_in(yin),
      .ack_in(ack_sat), .req_out(req_sat), .xpos_bus(xbus_sat), .ypos_bus(ybus_sat),
      .busy(busy_sat), .drop_cnt(drop_sat));

   // Slow-domain receiver: ack rises 3 slow cycles after req, falls 2 slow cycles after req drops.
   int rc_m, rc_nd;
   always @(posedge clk74 or negedge rst_n) begin
      if (!rst_n) begin
         ack_m <= 1'b0; rc_m <= 0;
      end else if (!ack_m) begin
         if (req_out) begin
            if (rc_m == 2) begin ack_m <= 1'b1; rc_m <= 0; end else rc_m <= rc_m + 1;
         end else rc_m <= 0;
      end else begin
         if (!req_out) begin
            if (rc_m == 1) begin ack_m <= 1'b0; rc_m <= 0; end else rc_m <= rc_m + 1;
         end else rc_m <= 0;
      end
   end

   always @(posedge clk74 or negedge rst_n) begin
      if (!rst_n) begin
         ack_nd <= 1'b0; rc_nd <= 0;
      end else if (!ack_nd) begin
         if (req_nd) begin
            if (rc_nd == 2) begin ack_nd <= 1'b1; rc_nd <= 0; end else rc_nd <= rc_nd + 1;
         end else rc_nd <= 0;
      end else begin
         if (!req_nd) begin
            if (rc_nd == 1) begin ack_nd <= 1'b0; rc_nd <= 0; end else rc_nd <= rc_nd + 1;
         end else rc_nd <= 0;
      end
   end

   // Record every pair that appears on the bus at a req rise.
   logic [2*W-1:0] launches[$];
   logic req_prev = 1'b0, req_prev_nd = 1'b0;
   int   launches_nd = 0;
   always @(negedge clk100MHz) begin
      if (req_out && !req_prev) launches.push_back({xpos_bus, ypos_bus});
      if (req_nd && !req_prev_nd) launches_nd <= launches_nd + 1;
      req_prev    <= req_out;
      req_prev_nd <= req_nd;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk100MHz);
      #1;
   endtask

   task automatic strobe(input logic [W-1:0] x, input logic [W-1:0] y);
      xin = x; yin = y; pv = 1'b1;
      tick();
      pv = 1'b0;
   endtask

   task automatic wait_idle(input logic [W-1:0] ex, input logic [W-1:0] ey, input bit stab,
                            input string nm);
      int  n = 0;
      bit  moved = 1'b0;
      while ((busy || busy_nd) && n < 400) begin
         if (stab && (xpos_bus !== ex || ypos_bus !== ey)) moved = 1'b1;
         tick();
         n++;
      end
      chk({nm, "_idle"}, {31'd0, busy || busy_nd}, 32'd0);
      if (stab) chk({nm, "_stable"}, {31'd0, moved}, 32'd0);
   endtask

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         launch;
      logic [W-1:0] bx;
      logic [W-1:0] by;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{12'd0,    12'd0,    1'b0, 12'd0,    12'd0};
      tbl[1] = '{12'd100,  12'd200,  1'b1, 12'd100,  12'd200};
      tbl[2] = '{12'd100,  12'd200,  1'b0, 12'd100,  12'd200};
      tbl[3] = '{12'd7,    12'd7,    1'b1, 12'd7,    12'd7};
      tbl[4] = '{12'd4095, 12'd0,    1'b1, 12'd4095, 12'd0};
      tbl[5] = '{12'd4095, 12'd0,    1'b0, 12'd4095, 12'd0};
      tbl[6] = '{12'd0,    12'd4095, 1'b1, 12'd0,    12'd4095};

      // Reset hold
      rst_n = 1'b0;
      repeat (10) tick();
      chk("rst_req",  {31'd0, req_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_xbus", {20'd0, xpos_bus}, 32'd0);
      chk("rst_ybus", {20'd0, ypos_bus}, 32'd0);
      chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Single transfers and dup filtering from IDLE
      for (int i = 0; i < 7; i++) begin
         strobe(tbl[i].x, tbl[i].y);
         chk($sformatf("vec%0d_req", i),  {31'd0, req_out}, {31'd0, tbl[i].launch});
         chk($sformatf("vec%0d_busy", i), {31'd0, busy},    {31'd0, tbl[i].launch});
         chk($sformatf("vec%0d_xbus", i), {20'd0, xpos_bus}, {20'd0, tbl[i].bx});
         chk($sformatf("vec%0d_ybus", i), {20'd0, ypos_bus}, {20'd0, tbl[i].by});
         wait_idle(tbl[i].bx, tbl[i].by, tbl[i].launch, $sformatf("vec%0d", i));
      end
      chk("vec_drop", {16'd0, drop_cnt}, 32'd0);
      chk("vec_launches", launches.size(), 32'd4);

      // Coalescing: four back-to-back strobes
      launches.delete();
      pv = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         xin = W'(k); yin = W'(k);
         tick();
         if (k == 1) chk("coal_first_req", {31'd0, req_out}, 32'd1);
      end
      pv = 1'b0;
      wait_idle('0, '0, 1'b0, "coal");
      chk("coal_launches", launches.size(), 32'd2);
      chk("coal_first",  {8'd0, launches[0]}, {8'd0, 12'd1, 12'd1});
      chk("coal_second", {8'd0, launches[1]}, {8'd0, 12'd4, 12'd4});
      chk("coal_drop", {16'd0, drop_cnt}, 32'd2);

      // Completion collision under a hand-driven ack
      launches.delete();
      man_mode = 1'b1;
      ack_man  = 1'b0;
      strobe(12'd10, 12'd10);
      chk("col_req", {31'd0, req_out}, 32'd1);
      strobe(12'd5, 12'd5);
      ack_man = 1'b1;
      repeat (6) tick();
      chk("col_req_fall", {31'd0, req_out}, 32'd0);
      chk("col_bus_held", {20'd0, xpos_bus}, 32'd10);
      ack_man = 1'b0;
      repeat (2) tick();
      strobe(12'd6, 12'd6);
      chk("col_relaunch", {31'd0, req_out}, 32'd1);
      chk("col_xbus", {20'd0, xpos_bus}, 32'd6);
      chk("col_ybus", {20'd0, ypos_bus}, 32'd6);
      chk("col_drop", {16'd0, drop_cnt}, 32'd3);
      ack_man = 1'b1;
      repeat (6) tick();
      ack_man = 1'b0;
      wait_idle(12'd6, 12'd6, 1'b1, "col");
      chk("col_launches", launches.size(), 32'd2);
      chk("col_last", {8'd0, launches[1]}, {8'd0, 12'd6, 12'd6});
      man_mode = 1'b0;

      // Repeated (7,7): filtered by the default instance, sent twice with SKIP_DUP=0
      launches.delete();
      for (int r = 0; r < 2; r++) begin
         xin = 12'd7; yin = 12'd7; pv = 1'b1; pv_nd = 1'b1;
         tick();
         pv = 1'b0; pv_nd = 1'b0;
         wait_idle(12'd7, 12'd7, 1'b1, $sformatf("dup%0d", r));
      end
      chk("dup_launches", launches.size(), 32'd1);
      chk("nodup_launches", launches_nd, 32'd2);
      chk("nodup_drop", {16'd0, drop_nd}, 32'd0);
      chk("nodup_xbus", {20'd0, xbus_nd}, 32'd7);

      // Saturation: ack held low, 21 overwrites after the first launch
      for (int i = 0; i < 22; i++) begin
         xin = W'(i + 1); yin = W'(i + 1); pv_sat = 1'b1;
         tick();
         if (i == 11) chk("sat_mid", {28'd0, drop_sat}, 32'd10);
         if (i == 16) chk("sat_reach", {28'd0, drop_sat}, 32'd15);
      end
      pv_sat = 1'b0;
      tick();
      chk("sat_final", {28'd0, drop_sat}, 32'd15);
      chk("sat_req",   {31'd0, req_sat}, 32'd1);
      chk("sat_xbus",  {20'd0, xbus_sat}, 32'd1);
      chk("sat_ybus",  {20'd0, ybus_sat}, 32'd1);

      // Asynchronous reset in the middle of REQ_HI
      strobe(12'd300, 12'd300);
      chk("arst_pre_req", {31'd0, req_out}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req",  {31'd0, req_out}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_xbus", {20'd0, xpos_bus}, 32'd0);
      chk("arst_drop", {16'd0, drop_cnt}, 32'd0);
      chk("arst_sat_drop", {28'd0, drop_sat}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
